// File: rtl/gate_vector_checker.sv
// -----------------------------------------------------------------------------
// gate_vector_checker
//
// Self-checking harness for a two-input logic gate. A run starts on `start`.
// The four input combinations {a,b} = 00, 01, 10, 11 are driven in that order.
// Each combination is held for SETTLE_CYCLES clocks. The gate output `y` is
// then sampled and compared against the truth table TRUTH. A summary
// (pass, err_count) and a per-vector failure mask are reported.
//
// Parameters
//   SETTLE_CYCLES : clocks each vector is held before `y` is sampled (1..255)
//   TRUTH         : expected y indexed by {a,b}; bit 0 = 00, bit 3 = 11
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   start     in   begin a run (sampled only when idle or done)
//   a, b      out  registered gate inputs
//   y         in   gate output under test, synchronous to clk
//   busy      out  high while vectors are being driven
//   done      out  one-cycle pulse when a run completes
//   pass      out  last completed run had zero mismatches
//   err_count out  number of mismatching vectors in the last run (0..4)
//   fail_mask out  bit i set when vector i = {a,b} mismatched
// -----------------------------------------------------------------------------
module gate_vector_checker #(
    parameter int         SETTLE_CYCLES = 4,
    parameter logic [3:0] TRUTH         = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    // Settle counter width: one spare bit so SETTLE_CYCLES-1 always fits.
    localparam int              SC_W    = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_ZERO = SC_W'(0);
    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [1:0]      vi_r;
    logic [1:0]      vi_nxt_s;
    logic [SC_W-1:0] sc_r;
    logic [SC_W-1:0] sc_nxt_s;

    logic            a_nxt_s;
    logic            b_nxt_s;
    logic            busy_nxt_s;
    logic            done_nxt_s;
    logic            pass_nxt_s;
    logic [2:0]      err_nxt_s;
    logic [3:0]      mask_nxt_s;

    logic            sample_s;
    logic            last_s;
    logic            miss_s;
    logic [2:0]      err_after_s;
    logic [3:0]      mask_after_s;

    // Expected gate output for vector index idx.
    function automatic logic expected_y(input logic [1:0] idx);
        return TRUTH[idx];
    endfunction

    // One-hot mask bit for vector index idx.
    function automatic logic [3:0] vec_bit(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Sample strobe, final-vector flag and the result of comparing y this cycle.
    always_comb begin
        sample_s = (state_r == RUN) && (sc_r == SC_LAST);
        last_s   = sample_s && (vi_r == 2'd3);
        miss_s   = sample_s && (y != expected_y(vi_r));
        if (miss_s) begin
            err_after_s  = err_count + 3'd1;
            mask_after_s = fail_mask | vec_bit(vi_r);
        end else begin
            err_after_s  = err_count;
            mask_after_s = fail_mask;
        end
    end

    // State register and all registered outputs; rst has priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            vi_r      <= 2'd0;
            sc_r      <= SC_ZERO;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            vi_r      <= vi_nxt_s;
            sc_r      <= sc_nxt_s;
            a         <= a_nxt_s;
            b         <= b_nxt_s;
            busy      <= busy_nxt_s;
            done      <= done_nxt_s;
            pass      <= pass_nxt_s;
            err_count <= err_nxt_s;
            fail_mask <= mask_nxt_s;
        end
    end

    // Next-state logic: start is honoured only from IDLE and DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the datapath and outputs, computed for the edge that
    // produces state_nxt_s so every output stays a plain register.
    always_comb begin
        vi_nxt_s   = vi_r;
        sc_nxt_s   = sc_r;
        a_nxt_s    = a;
        b_nxt_s    = b;
        busy_nxt_s = busy;
        done_nxt_s = 1'b0;
        pass_nxt_s = pass;
        err_nxt_s  = err_count;
        mask_nxt_s = fail_mask;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    // Entering RUN: clear old results and drive vector 00.
                    vi_nxt_s   = 2'd0;
                    sc_nxt_s   = SC_ZERO;
                    a_nxt_s    = 1'b0;
                    b_nxt_s    = 1'b0;
                    busy_nxt_s = 1'b1;
                    pass_nxt_s = 1'b0;
                    err_nxt_s  = 3'd0;
                    mask_nxt_s = 4'd0;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            RUN: begin
                if (last_s) begin
                    // Entering DONE: pass includes the vector-3 comparison.
                    vi_nxt_s   = 2'd0;
                    sc_nxt_s   = SC_ZERO;
                    a_nxt_s    = 1'b0;
                    b_nxt_s    = 1'b0;
                    busy_nxt_s = 1'b0;
                    done_nxt_s = 1'b1;
                    err_nxt_s  = err_after_s;
                    mask_nxt_s = mask_after_s;
                    pass_nxt_s = (err_after_s == 3'd0);
                end else if (sample_s) begin
                    // Record this vector and move on to the next one.
                    vi_nxt_s   = vi_r + 2'd1;
                    sc_nxt_s   = SC_ZERO;
                    a_nxt_s    = vi_nxt_s[1];
                    b_nxt_s    = vi_nxt_s[0];
                    err_nxt_s  = err_after_s;
                    mask_nxt_s = mask_after_s;
                end else begin
                    sc_nxt_s = sc_r + SC_ONE;
                end
            end
            default: begin
                // Unreachable encoding: return everything to reset values.
                vi_nxt_s   = 2'd0;
                sc_nxt_s   = SC_ZERO;
                a_nxt_s    = 1'b0;
                b_nxt_s    = 1'b0;
                busy_nxt_s = 1'b0;
                pass_nxt_s = 1'b0;
                err_nxt_s  = 3'd0;
                mask_nxt_s = 4'd0;
            end
        endcase
    end

endmodule
